// File: rtl/glb_pkg.sv
// -----------------------------------------------------------------------------
// glb_pkg
//   Shared definitions for the glb scratchpad and its initiator-side controller.
//
//   Contents:
//     GLB_DEPTH     number of rows in the scratchpad (64)
//     GLB_ADDR_W    row address width (6)
//     GLB_PASS_W    width of the pass counter (up to 16 passes)
//     glb_state_e   controller state encoding
//     glb_next_row  helper: row index increment with wrap at a programmable end
// -----------------------------------------------------------------------------
package glb_pkg;

  localparam int GLB_DEPTH  = 64;
  localparam int GLB_ADDR_W = 6;
  localparam int GLB_PASS_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_ACCUM     = 3'd2,
    ST_DRAIN_REQ = 3'd3,
    ST_DRAIN_CAP = 3'd4,
    ST_DRAIN_OUT = 3'd5
  } glb_state_e;

  // Next row index: wraps to 0 once the last programmed row is reached.
  function automatic logic [GLB_ADDR_W-1:0] glb_next_row(
    input logic [GLB_ADDR_W-1:0] row,
    input logic [GLB_ADDR_W-1:0] last
  );
    if (row == last) begin
      return '0;
    end
    return row + 1'b1;
  endfunction

endpackage

// File: rtl/glb.sv
// -----------------------------------------------------------------------------
// glb
//   64-row scratchpad with in-place accumulate and single-cycle bulk clear.
//
//   Ports:
//     clk       clock
//     ready     low: every row is cleared to zero on the clock edge
//     rw        1: store data_in at address; 0: load row into data_out
//     add       1: store accumulates into the row; 0: overwrites it
//     address   row address
//     data_in   store / accumulate operand
//     data_out  registered load result, valid one cycle after a load
//
//   Accumulation wraps modulo 2^num_bits. The bulk clear needs every row to
//   be reachable in one cycle, so the array maps to registers, not block RAM.
// -----------------------------------------------------------------------------
module glb
  import glb_pkg::*;
#(
  parameter int num_bits = 16
) (
  input  logic                  clk,
  input  logic                  ready,
  input  logic                  rw,
  input  logic                  add,
  input  logic [GLB_ADDR_W-1:0] address,
  input  logic [num_bits-1:0]   data_in,
  output logic [num_bits-1:0]   data_out
);

  logic [num_bits-1:0] mem_q [GLB_DEPTH];
  logic [num_bits-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (!ready) begin
      for (int i = 0; i < GLB_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (rw) begin
      if (add) begin
        mem_q[address] <= mem_q[address] + data_in;
      end else begin
        mem_q[address] <= data_in;
      end
    end else begin
      data_out_q <= mem_q[address];
    end
  end

  assign data_out = data_out_q;

endmodule

// File: rtl/glb_ctrl.sv
// -----------------------------------------------------------------------------
// glb_ctrl
//   Initiator-side controller for the glb scratchpad. Writes a stream of
//   partial sums into consecutive rows over one or more passes (the first pass
//   overwrites, later passes accumulate), then drains the finished rows out
//   through a valid/ready stream.
//
//   Ports:
//     w_clk, w_rst         clock, synchronous active-high reset
//     w_start              start a job (honoured in IDLE only)
//     w_len_m1             rows - 1, latched on start
//     w_passes_m1          passes - 1, latched on start
//     w_in_valid/w_in_data input partial-sum stream (r_in_ready back)
//     r_out_valid/r_out_data, w_out_ready  drained-row stream
//     r_glb_*              glb control pins (combinational)
//     w_glb_data_out       glb load result
//     r_busy               high in every state but IDLE
//     r_done               one-cycle pulse after the last drained row
//
//   Drain sequence per row: REQ presents a load, CAP captures the glb output
//   register, OUT holds the word until the consumer takes it.
// -----------------------------------------------------------------------------
module glb_ctrl
  import glb_pkg::*;
#(
  parameter int num_bits = 16
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_start,
  input  logic [GLB_ADDR_W-1:0] w_len_m1,
  input  logic [GLB_PASS_W-1:0] w_passes_m1,
  input  logic                  w_in_valid,
  input  logic [num_bits-1:0]   w_in_data,
  output logic                  r_in_ready,
  output logic                  r_out_valid,
  output logic [num_bits-1:0]   r_out_data,
  input  logic                  w_out_ready,
  output logic                  r_glb_ready,
  output logic                  r_glb_rw,
  output logic                  r_glb_add,
  output logic [GLB_ADDR_W-1:0] r_glb_address,
  output logic [num_bits-1:0]   r_glb_data_in,
  input  logic [num_bits-1:0]   w_glb_data_out,
  output logic                  r_busy,
  output logic                  r_done
);

  glb_state_e            state_q, state_d;
  logic [GLB_ADDR_W-1:0] row_q, row_d;
  logic [GLB_ADDR_W-1:0] len_q, len_d;
  logic [GLB_PASS_W-1:0] pass_q, pass_d;
  logic [GLB_PASS_W-1:0] passes_q, passes_d;
  logic [num_bits-1:0]   out_data_q, out_data_d;
  logic                  done_q, done_d;

  logic row_last;
  logic pass_last;
  logic in_hs;
  logic out_hs;

  assign row_last  = (row_q == len_q);
  assign pass_last = (pass_q == passes_q);
  assign in_hs     = (state_q == ST_ACCUM) && w_in_valid;
  assign out_hs    = (state_q == ST_DRAIN_OUT) && w_out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    len_d      = len_q;
    pass_d     = pass_q;
    passes_d   = passes_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          len_d    = w_len_m1;
          passes_d = w_passes_m1;
          state_d  = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        row_d   = '0;
        pass_d  = '0;
        state_d = ST_ACCUM;
      end

      ST_ACCUM: begin
        if (in_hs) begin
          // Row wrap and pass advance happen on the same handshake, so the
          // stream continues without a bubble into the next pass.
          row_d = glb_next_row(row_q, len_q);
          if (row_last) begin
            if (pass_last) begin
              state_d = ST_DRAIN_REQ;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end
        end
      end

      ST_DRAIN_REQ: begin
        state_d = ST_DRAIN_CAP;
      end

      ST_DRAIN_CAP: begin
        // glb output register holds the row requested in DRAIN_REQ.
        out_data_d = w_glb_data_out;
        state_d    = ST_DRAIN_OUT;
      end

      ST_DRAIN_OUT: begin
        if (out_hs) begin
          if (row_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_DRAIN_REQ;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      len_q      <= '0;
      pass_q     <= '0;
      passes_q   <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      len_q      <= len_d;
      pass_q     <= pass_d;
      passes_q   <= passes_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything is forced low while reset is held; that includes
  // r_glb_ready, so the scratchpad is wiped during reset as well.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_in_ready    = 1'b0;
    r_out_valid   = 1'b0;
    r_out_data    = '0;
    r_glb_ready   = 1'b0;
    r_glb_rw      = 1'b0;
    r_glb_add     = 1'b0;
    r_glb_address = '0;
    r_glb_data_in = '0;
    r_busy        = 1'b0;
    r_done        = 1'b0;

    if (!w_rst) begin
      r_out_data  = out_data_q;
      r_done      = done_q;
      r_busy      = (state_q != ST_IDLE);
      r_glb_ready = 1'b1;

      case (state_q)
        ST_CLEAR: begin
          r_glb_ready = 1'b0;
        end

        ST_ACCUM: begin
          r_in_ready    = 1'b1;
          // Store only on an accepted word; idle input cycles become loads.
          r_glb_rw      = w_in_valid;
          r_glb_add     = (pass_q != '0);
          r_glb_address = row_q;
          r_glb_data_in = w_in_data;
        end

        ST_DRAIN_REQ, ST_DRAIN_CAP: begin
          r_glb_address = row_q;
        end

        ST_DRAIN_OUT: begin
          r_out_valid   = 1'b1;
          r_glb_address = row_q;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_glb_ctrl
//   Bench for glb_ctrl driving a real glb instance. Expected drained rows are
//   computed from the input word list with plain modular sums.
// -----------------------------------------------------------------------------
module tb_glb_ctrl;
  import glb_pkg::*;

  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            w_rst;
  logic            w_start;
  logic [5:0]      w_len_m1;
  logic [3:0]      w_passes_m1;
  logic            w_in_valid;
  logic [NB-1:0]   w_in_data;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [NB-1:0]   r_out_data;
  logic            w_out_ready;
  logic            r_glb_ready;
  logic            r_glb_rw;
  logic            r_glb_add;
  logic [5:0]      r_glb_address;
  logic [NB-1:0]   r_glb_data_in;
  logic [NB-1:0]   w_glb_data_out;
  logic            r_busy;
  logic            r_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [NB-1:0] words [0:1023];
  logic [NB-1:0] expect_row [0:63];

  always #5 clk = ~clk;

  glb_ctrl #(.num_bits(NB)) dut (
    .w_clk         (clk),
    .w_rst         (w_rst),
    .w_start       (w_start),
    .w_len_m1      (w_len_m1),
    .w_passes_m1   (w_passes_m1),
    .w_in_valid    (w_in_valid),
    .w_in_data     (w_in_data),
    .r_in_ready    (r_in_ready),
    .r_out_valid   (r_out_valid),
    .r_out_data    (r_out_data),
    .w_out_ready   (w_out_ready),
    .r_glb_ready   (r_glb_ready),
    .r_glb_rw      (r_glb_rw),
    .r_glb_add     (r_glb_add),
    .r_glb_address (r_glb_address),
    .r_glb_data_in (r_glb_data_in),
    .w_glb_data_out(w_glb_data_out),
    .r_busy        (r_busy),
    .r_done        (r_done)
  );

  glb #(.num_bits(NB)) u_glb (
    .clk     (clk),
    .ready   (r_glb_ready),
    .rw      (r_glb_rw),
    .add     (r_glb_add),
    .address (r_glb_address),
    .data_in (r_glb_data_in),
    .data_out(w_glb_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: each row is the wrapped sum of its word in every pass.
  task automatic build_model(input int rows, input int passes);
    for (int r = 0; r < rows; r++) begin
      int unsigned acc;
      acc = 0;
      for (int p = 0; p < passes; p++) begin
        acc = acc + words[p*rows + r];
      end
      expect_row[r] = acc[NB-1:0];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, r_in_ready, 0);
    check({tag, "_out_valid"}, r_out_valid, 0);
    check({tag, "_out_data"}, r_out_data, 0);
    check({tag, "_glb_ready"}, r_glb_ready, 0);
    check({tag, "_glb_rw"}, r_glb_rw, 0);
    check({tag, "_glb_add"}, r_glb_add, 0);
    check({tag, "_glb_address"}, r_glb_address, 0);
    check({tag, "_glb_data_in"}, r_glb_data_in, 0);
    check({tag, "_busy"}, r_busy, 0);
    check({tag, "_done"}, r_done, 0);
  endtask

  // stall < 0: random 0..2 cycles of w_out_ready low per word.
  task automatic run_job(input int len_m1, input int passes_m1, input int gap_pct,
                         input int stall, input bit abort);
    int rows;
    int total;
    int idx;
    int cyc;
    int k;
    int wait_cnt;
    int stall_this;
    rows  = len_m1 + 1;
    total = rows * (passes_m1 + 1);
    build_model(rows, passes_m1 + 1);
    $display("job start: rows=%0d passes=%0d gap=%0d%% stall=%0d abort=%0d",
             rows, passes_m1 + 1, gap_pct, stall, abort);

    w_len_m1    = len_m1[5:0];
    w_passes_m1 = passes_m1[3:0];
    w_start     = 1'b1;
    @(posedge clk); #1;
    w_start     = 1'b0;
    // Changing these after start must not matter: they are latched.
    w_len_m1    = 6'($urandom);
    w_passes_m1 = 4'($urandom);
    #1;
    check("clear_glb_ready", r_glb_ready, 0);
    check("clear_busy", r_busy, 1);
    check("clear_in_ready", r_in_ready, 0);
    @(posedge clk); #1;
    check("start_to_in_ready", r_in_ready, 1);

    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 20000) begin
      bit v;
      v          = ($urandom_range(99) >= gap_pct);
      w_in_valid = v;
      w_in_data  = words[idx];
      w_start    = 1'($urandom_range(1));
      #1;
      check("accum_in_ready", r_in_ready, 1);
      check("accum_glb_rw", r_glb_rw, v);
      if (v) begin
        check("accum_addr", r_glb_address, idx % rows);
        check("accum_add", r_glb_add, (idx >= rows));
        check("accum_data_in", r_glb_data_in, words[idx]);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < total) check("accum_timeout", idx, total);

    // One cycle after leaving ACCUM.
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    #1;
    check("drain_req_in_ready", r_in_ready, 0);
    check("drain_req_rw", r_glb_rw, 0);
    check("drain_req_addr", r_glb_address, 0);
    check("drain_req_valid", r_out_valid, 0);
    @(posedge clk); #1;
    check("drain_cap_valid", r_out_valid, 0);
    @(posedge clk); #1;
    check("first_valid_latency", r_out_valid, 1);

    k          = 0;
    cyc        = 0;
    wait_cnt   = 0;
    stall_this = (stall < 0) ? $urandom_range(2) : stall;
    while (k < rows && cyc < 20000) begin
      w_start = 1'($urandom_range(1));
      if (r_out_valid) begin
        check("out_data", r_out_data, expect_row[k]);
        check("drain_rw", r_glb_rw, 0);
        if (abort) begin
          w_start = 1'b0;
          w_rst   = 1'b1;
          #1;
          check_all_zero("rst_in_drain");
          @(posedge clk); #1;
          w_rst = 1'b0;
          #1;
          check("post_rst_busy", r_busy, 0);
          check("post_rst_out_valid", r_out_valid, 0);
          check("post_rst_out_data", r_out_data, 0);
          check("post_rst_glb_ready", r_glb_ready, 1);
          check("post_rst_done", r_done, 0);
          $display("job aborted by reset at row %0d", k);
          return;
        end
        if (wait_cnt >= stall_this) begin
          w_out_ready = 1'b1;
          $display("out row %0d data 0x%04h (expected 0x%04h)", k, r_out_data, expect_row[k]);
          k++;
          wait_cnt   = 0;
          stall_this = (stall < 0) ? $urandom_range(2) : stall;
        end else begin
          w_out_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        w_out_ready = 1'($urandom_range(1));
      end
      check("drain_no_done", r_done, 0);
      @(posedge clk); #1;
      cyc++;
    end
    if (k < rows) check("drain_timeout", k, rows);

    w_start     = 1'b0;
    w_out_ready = 1'b0;
    #1;
    check("done_pulse", r_done, 1);
    check("done_busy", r_busy, 0);
    check("done_out_valid", r_out_valid, 0);
    check("idle_glb_ready", r_glb_ready, 1);
    @(posedge clk); #1;
    check("done_single", r_done, 0);
    $display("job end: rows=%0d", rows);
  endtask

  initial begin
    int r;
    int p;
    w_rst       = 1'b1;
    w_start     = 1'b0;
    w_len_m1    = '0;
    w_passes_m1 = '0;
    w_in_valid  = 1'b0;
    w_in_data   = '0;
    w_out_ready = 1'b0;

    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    w_rst = 1'b0;
    #1;
    check("idle_glb_ready", r_glb_ready, 1);
    check("idle_busy", r_busy, 0);
    check("idle_in_ready", r_in_ready, 0);

    // Single pass.
    for (int i = 0; i < 4; i++) words[i] = NB'(i + 1);
    run_job(3, 0, 0, 0, 0);

    // Accumulation: 5+5+5 and 7+7+7.
    for (int i = 0; i < 6; i++) words[i] = (i % 2 == 0) ? 16'd5 : 16'd7;
    run_job(1, 2, 0, 0, 0);

    // Overflow wrap.
    words[0] = 16'hFFFF;
    words[1] = 16'hFFFF;
    run_job(0, 1, 0, 0, 0);

    // Backpressure on both sides.
    for (int i = 0; i < 32; i++) words[i] = NB'($urandom);
    run_job(7, 3, 40, 5, 0);

    // Full depth, then a single-row job to show the stale rows were cleared.
    for (int i = 0; i < 1024; i++) words[i] = 16'd1;
    run_job(63, 15, 0, -1, 0);
    words[0] = 16'd9;
    run_job(0, 0, 0, 0, 0);

    // Reset mid-drain, then a fresh job.
    for (int i = 0; i < 18; i++) words[i] = NB'($urandom);
    run_job(5, 2, 20, 0, 1);
    run_job(5, 2, 20, -1, 0);

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      r = $urandom_range(63);
      p = $urandom_range(15);
      for (int i = 0; i < (r + 1) * (p + 1); i++) words[i] = NB'($urandom);
      run_job(r, p, $urandom_range(50), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
